// File: rtl/stim_lcg_gen_if.sv
// Bus bundle for stim_lcg_gen: run control, LCG stimulus out, response in.
// master = the side that drives runs and observes stimulus; slave = the generator.
interface stim_lcg_gen_if #(
    parameter int IN_W  = 142,
    parameter int OUT_W = 159,
    parameter int CYC_W = 32
);
    logic             start;
    logic [31:0]      seed;
    logic [CYC_W-1:0] cycles;
    logic [1:0]       mode;
    logic             stall;
    logic [OUT_W-1:0] resp;
    logic [IN_W-1:0]  stim;
    logic [CYC_W-1:0] cyc;
    logic             busy;
    logic             done;
    logic [31:0]      signature;

    modport master (
        output start, seed, cycles, mode, stall, resp,
        input  stim, cyc, busy, done, signature
    );

    modport slave (
        input  start, seed, cycles, mode, stall, resp,
        output stim, cyc, busy, done, signature
    );
endinterface

// File: rtl/stim_lcg_gen.sv
// LCG / walking-one stimulus generator with a 32-bit MISR compressing the response.
// Runs IDLE -> PRIME (settle) -> RUN (cycles steps, stallable) -> DONE (1-cycle pulse).
module stim_lcg_gen #(
    parameter int IN_W  = 142,
    parameter int OUT_W = 159,
    parameter int CYC_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    stim_lcg_gen_if.slave  bus
);

    localparam int NW = (IN_W + 31) / 32;
    localparam int FW = (OUT_W + 31) / 32;

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [IN_W-1:0]  r_stim;
    logic [CYC_W-1:0] r_cyc;
    logic [CYC_W-1:0] r_cycles;
    logic [31:0]      r_sig;
    logic [31:0]      r_lcg;
    logic [1:0]       r_mode;

    logic [31:0]      w_lcg_src;
    logic [NW*32-1:0] w_words;
    logic [31:0]      w_lcg_next;
    logic             w_start;
    logic             w_step;
    logic             w_last;
    logic             w_busy;
    logic             w_done;

    function automatic logic [31:0] lcg_step(input logic [31:0] x);
        return x * 32'h41C64E6D + 32'h0000_3039;
    endfunction

    // Word k of a vector is step^(k+1) of the source; the top word doubles as the advanced state.
    function automatic logic [NW*32-1:0] lcg_words(input logic [31:0] x);
        logic [31:0]      s;
        logic [NW*32-1:0] v;
        s = x;
        v = '0;
        for (int k = 0; k < NW; k++) begin
            s = lcg_step(s);
            v[k*32 +: 32] = s;
        end
        return v;
    endfunction

    function automatic logic [31:0] fold_resp(input logic [OUT_W-1:0] r);
        logic [FW*32-1:0] p;
        logic [31:0]      f;
        p = '0;
        p[OUT_W-1:0] = r;
        f = '0;
        for (int k = 0; k < FW; k++) begin
            f = f ^ p[k*32 +: 32];
        end
        return f;
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ f;
    endfunction

    assign w_lcg_src  = (r_state == S_IDLE) ? bus.seed : r_lcg;
    assign w_words    = lcg_words(w_lcg_src);
    assign w_lcg_next = w_words[NW*32-1 -: 32];
    assign w_start    = (r_state == S_IDLE) && bus.start;
    assign w_step     = (r_state == S_RUN) && !bus.stall;
    assign w_last     = (r_cyc + CYC_W'(1)) == r_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_PRIME;
            S_PRIME: w_next_state = (r_cycles == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_step && w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_PRIME, S_RUN: w_busy = 1'b1;
            S_DONE:         w_done = 1'b1;
            default:        ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stim   <= '0;
            r_cyc    <= '0;
            r_cycles <= '0;
            r_sig    <= '0;
            r_lcg    <= '0;
            r_mode   <= 2'd0;
        end else if (w_start) begin
            r_cycles <= bus.cycles;
            r_mode   <= (bus.mode == 2'd3) ? 2'd0 : bus.mode;
            r_cyc    <= '0;
            r_sig    <= '0;
            r_lcg    <= w_lcg_next;
            r_stim   <= (bus.mode == 2'd1) ? IN_W'(1) : w_words[IN_W-1:0];
        end else if (w_step) begin
            r_cyc <= r_cyc + CYC_W'(1);
            r_sig <= misr_step(r_sig, fold_resp(bus.resp));
            // Hold mode keeps both stim and LCG state frozen at the primed vector.
            unique case (r_mode)
                2'd1: r_stim <= (r_stim << 1) | (r_stim >> (IN_W - 1));
                2'd2: ;
                default: begin
                    r_stim <= w_words[IN_W-1:0];
                    r_lcg  <= w_lcg_next;
                end
            endcase
        end
    end

    assign bus.stim      = r_stim;
    assign bus.cyc       = r_cyc;
    assign bus.signature = r_sig;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;

endmodule

// File: tb/tb_stim_lcg_gen.sv
// Bench for stim_lcg_gen: index-based behavioural model checked every cycle on a
// default-width instance, plus directed literal checks and an 8-bit walking-one instance.
module tb_stim_lcg_gen;

    localparam int IN_A  = 142;
    localparam int OUT_A = 159;
    localparam int CYC_A = 32;
    localparam int NWA   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stim_lcg_gen_if #(.IN_W(IN_A), .OUT_W(OUT_A), .CYC_W(CYC_A)) ifa ();
    stim_lcg_gen_if #(.IN_W(8), .OUT_W(8), .CYC_W(8)) ifb ();

    stim_lcg_gen #(.IN_W(IN_A), .OUT_W(OUT_A), .CYC_W(CYC_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    stim_lcg_gen #(.IN_W(8), .OUT_W(8), .CYC_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    int total = 0;
    int bad   = 0;
    int tcount = 0;
    int t_start = 0;

    always @(posedge clk) tcount <= tcount + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (vector n computed directly from seed) ----------------
    function automatic logic [31:0] lcg(input logic [31:0] x);
        return x * 32'h41C64E6D + 32'h0000_3039;
    endfunction

    function automatic logic [IN_A-1:0] mvec(input logic [31:0] s, input int n);
        logic [31:0]       x;
        logic [NWA*32-1:0] v;
        x = s;
        v = '0;
        for (int i = 0; i < n * NWA; i++) x = lcg(x);
        for (int k = 0; k < NWA; k++) begin
            x = lcg(x);
            v[k*32 +: 32] = x;
        end
        return v[IN_A-1:0];
    endfunction

    function automatic logic [IN_A-1:0] mwalk(input int n);
        logic [IN_A-1:0] v;
        v = '0;
        v[n % IN_A] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] mfold(input logic [OUT_A-1:0] r);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < OUT_A; i++) f[i % 32] = f[i % 32] ^ r[i];
        return f;
    endfunction

    function automatic logic [31:0] mmisr(input logic [31:0] s, input logic [31:0] f);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return ((s << 1) | {31'b0, fb}) ^ f;
    endfunction

    function automatic int mmode(input logic [1:0] m);
        return (m == 2'd1) ? 1 : (m == 2'd2) ? 2 : 0;
    endfunction

    function automatic logic [IN_A-1:0] mexp(input int md, input logic [31:0] s, input int n);
        if (md == 1) return mwalk(n);
        if (md == 2) return mvec(s, 0);
        return mvec(s, n);
    endfunction

    int              m_ph = 0;
    int unsigned     m_n = 0;
    logic [31:0]     m_lim = '0;
    logic [31:0]     m_seed = '0;
    int              m_mode = 0;
    logic [31:0]     m_sig = '0;
    logic [IN_A-1:0] m_stim = '0;
    bit              m_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph   <= 0;
            m_n    <= 0;
            m_sig  <= '0;
            m_stim <= '0;
            m_ok   <= 1'b1;
        end else begin
            case (m_ph)
                0: if (ifa.start) begin
                    m_ph   <= 1;
                    m_seed <= ifa.seed;
                    m_lim  <= ifa.cycles;
                    m_mode <= mmode(ifa.mode);
                    m_n    <= 0;
                    m_sig  <= '0;
                    m_stim <= mexp(mmode(ifa.mode), ifa.seed, 0);
                end
                1: m_ph <= (m_lim == 0) ? 3 : 2;
                2: if (!ifa.stall) begin
                    m_n    <= m_n + 1;
                    m_sig  <= mmisr(m_sig, mfold(ifa.resp));
                    m_stim <= mexp(m_mode, m_seed, int'(m_n + 1));
                    if (m_n + 1 == m_lim) m_ph <= 3;
                end
                default: m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("m_stim", 256'(ifa.stim), 256'(m_stim));
            check("m_cyc", 256'(ifa.cyc), 256'(m_n));
            check("m_sig", 256'(ifa.signature), 256'(m_sig));
            check("m_busy", 256'(ifa.busy), 256'(m_ph == 1 || m_ph == 2));
            check("m_done", 256'(ifa.done), 256'(m_ph == 3));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [159:0] t;
        ifa.resp = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 5; k++) t[k*32 +: 32] = $urandom;
            ifa.resp = t[OUT_A-1:0];
        end
    end

    task automatic start_a(input logic [31:0] s, input logic [31:0] c, input logic [1:0] m);
        ifa.start  = 1'b1;
        ifa.seed   = s;
        ifa.cycles = c;
        ifa.mode   = m;
        @(negedge clk);
        ifa.start = 1'b0;
        t_start = tcount;
    endtask

    task automatic wait_done_a(input int maxc, output int lat);
        int n;
        n = 0;
        while (ifa.done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (ifa.done !== 1'b1) check("done_timeout", 256'(0), 256'(1));
        lat = tcount - t_start;
    endtask

    initial begin
        int lat;
        int n;
        logic [IN_A-1:0] mv;
        logic [IN_A-1:0] s0;
        logic [31:0]     c0;
        logic [31:0]     g0;
        logic [IN_A-1:0] rec1 [4];
        logic [IN_A-1:0] rec2 [4];
        logic [7:0]      walk [10];

        ifa.start = 1'b0; ifa.seed = '0; ifa.cycles = '0; ifa.mode = 2'd0; ifa.stall = 1'b0;
        ifb.start = 1'b0; ifb.seed = '0; ifb.cycles = '0; ifb.mode = 2'd0; ifb.stall = 1'b0;
        ifb.resp = '0;
        walk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_stim", 256'(ifa.stim), 256'(0));
        check("rst_cyc", 256'(ifa.cyc), 256'(0));
        check("rst_sig", 256'(ifa.signature), 256'(0));
        check("rst_busy", 256'(ifa.busy), 256'(0));
        check("rst_done", 256'(ifa.done), 256'(0));
        check("rst_b_stim", 256'(ifb.stim), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // seed 0, LCG mode, 3 steps
        start_a(32'd0, 32'd3, 2'd0);
        check("first_w0", 256'(ifa.stim[31:0]), 256'(32'h0000_3039));
        check("first_w1", 256'(ifa.stim[63:32]), 256'(32'hD3DC_167E));
        check("first_busy", 256'(ifa.busy), 256'(1));
        mv = mvec(32'd0, 0);
        check("model_w0", 256'(mv[31:0]), 256'(32'h0000_3039));
        check("model_w1", 256'(mv[63:32]), 256'(32'hD3DC_167E));
        wait_done_a(20, lat);
        check("lat_c3", 256'(lat), 256'(4));
        check("done_cyc3", 256'(ifa.cyc), 256'(3));
        ifa.start = 1'b1;
        ifa.seed  = 32'd5;
        @(negedge clk);
        ifa.start = 1'b0;
        check("done_pulse", 256'(ifa.done), 256'(0));
        check("idle_busy", 256'(ifa.busy), 256'(0));
        @(negedge clk);
        check("start_in_done_ignored", 256'(ifa.busy), 256'(0));

        // mode 3 behaves as LCG mode
        start_a(32'h1234_5678, 32'd4, 2'd3);
        wait_done_a(20, lat);
        check("m3_cyc", 256'(ifa.cyc), 256'(4));
        @(negedge clk);

        // hold mode keeps the primed vector
        start_a(32'd0, 32'd3, 2'd2);
        wait_done_a(20, lat);
        check("hold_w0", 256'(ifa.stim[31:0]), 256'(32'h0000_3039));
        @(negedge clk);

        // stall 5 cycles mid-run
        start_a(32'hCAFE_F00D, 32'd6, 2'd0);
        n = 0;
        while (ifa.cyc !== 32'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_reach", 256'(ifa.cyc), 256'(1));
        s0 = ifa.stim; c0 = ifa.cyc; g0 = ifa.signature;
        ifa.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_stim", 256'(ifa.stim), 256'(s0));
            check("stall_cyc", 256'(ifa.cyc), 256'(c0));
            check("stall_sig", 256'(ifa.signature), 256'(g0));
        end
        ifa.stall = 1'b0;
        wait_done_a(30, lat);
        check("lat_stall", 256'(lat), 256'(12));
        @(negedge clk);

        // zero-length run
        start_a(32'h0000_1111, 32'd0, 2'd0);
        wait_done_a(10, lat);
        check("lat_c0", 256'(lat), 256'(1));
        check("c0_sig", 256'(ifa.signature), 256'(0));
        check("c0_cyc", 256'(ifa.cyc), 256'(0));
        @(negedge clk);

        // reset mid-run, then replay the same seed
        start_a(32'h0BAD_BEEF, 32'd8, 2'd0);
        for (int j = 0; j < 4; j++) begin
            rec1[j] = ifa.stim;
            if (j < 3) @(negedge clk);
        end
        check("pre_rst_cyc", 256'(ifa.cyc), 256'(2));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_stim", 256'(ifa.stim), 256'(0));
        check("midrst_cyc", 256'(ifa.cyc), 256'(0));
        check("midrst_sig", 256'(ifa.signature), 256'(0));
        check("midrst_busy", 256'(ifa.busy), 256'(0));
        check("midrst_done", 256'(ifa.done), 256'(0));
        start_a(32'h0BAD_BEEF, 32'd8, 2'd0);
        for (int j = 0; j < 4; j++) begin
            rec2[j] = ifa.stim;
            if (j < 3) @(negedge clk);
        end
        for (int j = 0; j < 4; j++) check("replay", 256'(rec2[j]), 256'(rec1[j]));
        wait_done_a(20, lat);
        check("replay_cyc", 256'(ifa.cyc), 256'(8));
        @(negedge clk);

        // 8-bit walking one, 9 steps
        ifb.start  = 1'b1;
        ifb.mode   = 2'd1;
        ifb.cycles = 8'd9;
        @(negedge clk);
        ifb.start = 1'b0;
        check("walk_prime", 256'(ifb.stim), 256'(8'h01));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("walk_seq", 256'(ifb.stim), 256'(walk[k]));
        end
        check("walk_cyc", 256'(ifb.cyc), 256'(9));
        check("walk_done", 256'(ifb.done), 256'(1));
        @(negedge clk);
        check("walk_idle", 256'(ifb.busy), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1);
    end

endmodule

// File: doc/stim_lcg_gen.md
STIM_LCG_GEN -- requirements
Module: stim_lcg_gen

Interface
REQ-001: The module SHALL have parameter IN_W, default 142, giving the stimulus vector width (1..1024).
REQ-002: The module SHALL have parameter OUT_W, default 159, giving the response vector width (1..1024).
REQ-003: The module SHALL have parameter CYC_W, default 32, giving the cycle-counter width.
REQ-004: Port clk, input, 1 bit: single clock; all logic is sampled on the rising edge.
REQ-005: Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006: Port start, input, 1 bit: request to begin a run; honoured only in IDLE.
REQ-007: Port seed, input, 32 bits: initial LCG state; sampled on an accepted start.
REQ-008: Port cycles, input, CYC_W bits: number of RUN steps; sampled on an accepted start.
REQ-009: Port mode, input, 2 bits: 0 = LCG, 1 = walking-one, 2 = hold, 3 = treated as 0; sampled on an accepted start.
REQ-010: Port stall, input, 1 bit: freezes RUN progress.
REQ-011: Port resp, input, OUT_W bits: DUT response to be compressed.
REQ-012: Port stim, output, IN_W bits: stimulus vector.
REQ-013: Port cyc, output, CYC_W bits: count of completed RUN steps.
REQ-014: Port busy, output, 1 bit: high in PRIME and RUN.
REQ-015: Port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-016: Port signature, output, 32 bits: MISR of resp.

Function
REQ-017: The LCG step SHALL be x' = (x*32'h41C64E6D + 32'h3039) mod 2^32.
REQ-018: A vector SHALL be NW = ceil(IN_W/32) successive LCG steps: word k = step^(k+1)(state), placed in stim[32k+31:32k]; the last word is truncated to its low bits; the state then advances by NW steps.
REQ-019: States SHALL be IDLE, PRIME, RUN and DONE; the reset state is IDLE.
REQ-020: IDLE with start=1 -> PRIME. This clears cyc and signature, latches seed/cycles/mode, and loads stim with the first vector:
  - mode 0 or 2: the LCG vector from seed;
  - mode 1: the value 1.
REQ-021: PRIME -> RUN after exactly one cycle, with no stim change (settle cycle); if the latched cycles == 0, PRIME -> DONE instead.
REQ-022: Each RUN cycle with stall=0 SHALL:
  - load the next stim (mode 0: next LCG vector; mode 1: rotate left by 1 within IN_W, so bit IN_W-1 wraps to bit 0; mode 2: unchanged);
  - increment cyc;
  - update signature with resp.
REQ-023: RUN with stall=1 SHALL hold stim, cyc, signature and the LCG state.
REQ-024: RUN -> DONE on the step where cyc becomes equal to the latched cycles; DONE -> IDLE after one cycle; done=1 only in DONE.
REQ-025: The signature update SHALL be sig' = {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} XOR F, where F is the XOR of the 32-bit chunks of resp, zero-padded to a multiple of 32.
REQ-026: start in PRIME, RUN or DONE SHALL be ignored; start arriving in the same cycle as DONE SHALL also be ignored.
REQ-027: In IDLE, stim, cyc and signature SHALL hold their last values so they can be read after a run.
REQ-028: The cyc counter SHALL NOT wrap within a run, because RUN terminates at cycles ≤ 2^CYC_W-1.

Reset
REQ-029: rst=1 at any clock edge, including mid-run, SHALL force on the next edge:
  - state IDLE;
  - stim, cyc, signature and the LCG state to 0;
  - busy=0, done=0.
REQ-030: rst SHALL have priority over start and stall.

Verification
REQ-031: seed=0, mode=0, cycles=3, IN_W=142 -> one cycle after start: stim[31:0]=32'h00003039, stim[63:32]=32'hD3DC167E, busy=1.
REQ-032: mode=0, cycles=3 -> PRIME 1 cycle, RUN 3 cycles, done high for exactly 1 cycle with cyc=3, then busy=0.
REQ-033: mode=1, IN_W=8, cycles=9 -> stim sequence 01,02,04,...,80,01,02; final cyc=9.
REQ-034: stall held 5 cycles mid-run -> stim, cyc and signature constant; the run completes 5 cycles later than unstalled.
REQ-035: cycles=0 -> PRIME then DONE; signature=0; cyc=0.
REQ-036: rst asserted in RUN with cyc=2 -> next cycle all outputs 0, state IDLE; a subsequent start with the same seed reproduces an identical stim sequence.
